// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Requester side of the instruction-memory interface. Holds the
//               fetch PC, keeps at most one request outstanding to a
//               variable-latency memory, parks a returned word while decode
//               is stalled, and throws away in-flight fetches on redirect.
//               Owns the IF/ID pipeline register.
// Ports       : clk, reset            clock / synchronous active-high reset
//               imem_req, imem_addr   one-cycle fetch request and address
//               imem_rvalid, _rdata   response strobe and instruction word
//               stall_d, flush_d      hazard-unit hold / bubble controls
//               redirect, _target     taken branch / jump and its target
//               instr_d, pc_d,
//               pc_plus4_d, valid_d   IF/ID register contents
// Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_pc_f;
  logic [31:0] r_buf;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus4_d;
  logic        r_valid_d;

  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_word_avail;
  logic [31:0] w_word;
  logic        w_deliver;

  // Instructions are word aligned; the low target bits are simply dropped.
  assign w_target   = {redirect_target[31:2], 2'b00};
  assign w_pc_plus4 = r_pc_f + 32'd4;

  // A word is available either straight off the memory bus in WAIT or from
  // the one-entry buffer in HOLD. Responses in REQ/DRAIN are never used.
  assign w_word_avail = ((r_state == S_WAIT) && imem_rvalid) || (r_state == S_HOLD);
  assign w_word       = (r_state == S_HOLD) ? r_buf : imem_rdata;
  assign w_deliver    = w_word_avail && !stall_d && !flush_d && !redirect;

  // The request is suppressed while reset is asserted so a fetch is never
  // launched from a state that is about to be abandoned.
  assign imem_req  = (r_state == S_REQ) && !reset;
  assign imem_addr = r_pc_f;

  assign instr_d    = r_instr_d;
  assign pc_d       = r_pc_d;
  assign pc_plus4_d = r_pc_plus4_d;
  assign valid_d    = r_valid_d;

  // Fetch state machine and PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_REQ;
      r_pc_f  <= RESET_PC;
      r_buf   <= 32'd0;
    end else begin
      case (r_state)
        S_REQ: begin
          // The request goes out this cycle regardless; if a redirect
          // arrives alongside it, its response is already stale.
          if (redirect) begin
            r_pc_f  <= w_target;
            r_state <= S_DRAIN;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (redirect) begin
              r_pc_f  <= w_target;
              r_state <= S_REQ;
            end else if (w_deliver) begin
              r_pc_f  <= w_pc_plus4;
              r_state <= S_REQ;
            end else begin
              r_buf   <= imem_rdata;
              r_state <= S_HOLD;
            end
          end else if (redirect) begin
            r_pc_f  <= w_target;
            r_state <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (w_deliver) begin
            r_pc_f  <= w_pc_plus4;
            r_state <= S_REQ;
          end else if (redirect) begin
            r_pc_f  <= w_target;
            r_state <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (redirect) begin
            r_pc_f <= w_target;
          end
          if (imem_rvalid) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  // IF/ID register: flush beats stall beats deliver; anything else bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= 32'd0;
      r_pc_plus4_d <= 32'd0;
      r_valid_d    <= 1'b0;
    end else if (flush_d) begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (stall_d) begin
      r_instr_d <= r_instr_d;
      r_valid_d <= r_valid_d;
    end else if (w_deliver) begin
      r_instr_d    <= w_word;
      r_pc_d       <= r_pc_f;
      r_pc_plus4_d <= w_pc_plus4;
      r_valid_d    <= 1'b1;
    end else begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed bench for fetch_unit with a simple variable-latency
//               instruction memory whose contents are a fixed function of
//               the address.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_d;
  logic        flush_d;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;

  int checks = 0;
  int errors = 0;

  // Memory model state
  int          lat = 1;
  int          cnt = 0;
  bit          pending = 0;
  logic [31:0] paddr = 32'd0;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pc_plus4_d     (pc_plus4_d),
    .valid_d        (valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory: a request seen in cycle N is answered in cycle N+lat for one
  // cycle. Runs 1ns after the falling edge so stimulus has settled.
  always @(negedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    if (reset) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pending     = 1'b0;
        end
      end
      if (imem_req) begin
        pending = 1'b1;
        cnt     = lat;
        paddr   = imem_addr;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next valid IF/ID entry and check it.
  task automatic expect_fetch(input logic [31:0] pc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_d === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("fetch_seen", {31'd0, found}, 32'd1);
    check("pc_d", pc_d, pc);
    check("instr_d", instr_d, mem_word(pc));
    check("pc_plus4_d", pc_plus4_d, pc + 32'd4);
  endtask

  initial begin
    reset           = 1'b1;
    stall_d         = 1'b0;
    flush_d         = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'd0;
    imem_rvalid     = 1'b0;
    imem_rdata      = 32'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, valid_d}, 32'd0);
    check("rst_instr", instr_d, NOP);
    check("rst_pc_d", pc_d, 32'd0);
    check("rst_pc4_d", pc_plus4_d, 32'd0);
    reset = 1'b0;
    #1;
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);

    // Sequential fetch 0x00..0x08
    expect_fetch(32'h00);
    expect_fetch(32'h04);
    expect_fetch(32'h08);

    // Stall while 0x0C returns: word parked, IF/ID frozen, no request
    stall_d = 1'b1;
    @(negedge clk);
    check("stall_req0", {31'd0, imem_req}, 32'd0);
    check("stall_pc0", pc_d, 32'h08);
    @(negedge clk);
    check("hold_req1", {31'd0, imem_req}, 32'd0);
    check("hold_valid1", {31'd0, valid_d}, 32'd1);
    check("hold_pc1", pc_d, 32'h08);
    @(negedge clk);
    check("hold_req2", {31'd0, imem_req}, 32'd0);
    check("hold_instr2", instr_d, mem_word(32'h08));
    stall_d = 1'b0;
    @(negedge clk);
    check("unstall_valid", {31'd0, valid_d}, 32'd1);
    check("unstall_pc", pc_d, 32'h0C);
    check("unstall_instr", instr_d, mem_word(32'h0C));
    check("unstall_addr", imem_addr, 32'h10);

    expect_fetch(32'h10);
    expect_fetch(32'h14);
    expect_fetch(32'h18);
    expect_fetch(32'h1C);

    // Redirect in WAIT with latency 3: drain the stale 0x20 response
    lat = 3;
    @(negedge clk);
    check("wait_req", {31'd0, imem_req}, 32'd0);
    redirect        = 1'b1;
    redirect_target = 32'h0;
    @(negedge clk);
    redirect = 1'b0;
    check("drain_req0", {31'd0, imem_req}, 32'd0);
    check("drain_valid0", {31'd0, valid_d}, 32'd0);
    @(negedge clk);
    check("drain_req1", {31'd0, imem_req}, 32'd0);
    lat = 1;
    @(negedge clk);
    check("post_drain_req", {31'd0, imem_req}, 32'd1);
    check("post_drain_addr", imem_addr, 32'h0);
    check("post_drain_valid", {31'd0, valid_d}, 32'd0);
    expect_fetch(32'h00);

    // Redirect coincident with rvalid (plus flush): word dropped, target aligned
    @(negedge clk);
    redirect        = 1'b1;
    flush_d         = 1'b1;
    redirect_target = 32'h13;
    @(negedge clk);
    redirect = 1'b0;
    flush_d  = 1'b0;
    check("rdr_rv_valid", {31'd0, valid_d}, 32'd0);
    check("rdr_rv_req", {31'd0, imem_req}, 32'd1);
    check("rdr_rv_addr", imem_addr, 32'h10);
    expect_fetch(32'h10);

    // Reset in the middle of a WAIT
    lat = 3;
    @(negedge clk);
    reset = 1'b1;
    lat   = 1;
    @(negedge clk);
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_valid", {31'd0, valid_d}, 32'd0);
    check("midrst_instr", instr_d, NOP);
    check("midrst_addr", imem_addr, 32'h0);
    reset = 1'b0;
    #1;
    check("midrst_req_after", {31'd0, imem_req}, 32'd1);
    expect_fetch(32'h00);

    // Wrap: fetch at 0xFFFF_FFFC
    redirect        = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    check("wrap_drain_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("wrap_req", {31'd0, imem_req}, 32'd1);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4_d, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h0);
    check("wrap_next_req", {31'd0, imem_req}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
